voice_alloc: RTL and testbench

Polyphonic voice allocator/scheduler between the MIDI decoder and the synth engine. Accepts note-on/note-off/all-off events over a valid/ready handshake and assigns each note to one of VOICES voices, stealing a voice when all are busy. It drives the engine's keys_on vector, the one-cycle note_on strobe and the current key address, value and velocities. It consumes the engine's voice_free vector.

---
 rtl/voice_alloc.sv | 271 +++++++++++++++++++++++++++
 tb/tb_voice_alloc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_alloc.sv
// voice_alloc: polyphonic voice allocator between the MIDI decoder and the synth engine.
// Events are scanned one voice per cycle, then committed in a single cycle.
// Note-on target priority is: retrigger of a gated voice with the same key, then the
// lowest idle voice, then the oldest ungated voice, then the oldest voice overall.
// Optional build macro: SUSTAIN_PEDAL_EN adds the sustain input and per-voice hold bits.
module voice_alloc #(
  parameter int unsigned VOICES  = 8,
  parameter int unsigned V_WIDTH = 3
) (
  input  logic               OSC_CLK,
  input  logic               iRST,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic [1:0]         ev_type,
  input  logic [6:0]         ev_key,
  input  logic [6:0]         ev_vel,
  input  logic [VOICES-1:0]  voice_free,
`ifdef SUSTAIN_PEDAL_EN
  input  logic               sustain,
`endif
  output logic [VOICES-1:0]  keys_on,
  output logic               note_on,
  output logic               note_off,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [7:0]         cur_vel_off,
  output logic               stolen,
  output logic               off_miss
);

  localparam logic [1:0] EV_OFF  = 2'b00;
  localparam logic [1:0] EV_ON   = 2'b01;
  localparam logic [1:0] EV_ALL  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_COMMIT
  } state_t;

  state_t               state;

  // Captured event
  logic [1:0]           ev_type_q;
  logic [6:0]           ev_key_q;
  logic [6:0]           ev_vel_q;

  // Per-voice tables; ages are always a permutation of 0..VOICES-1
  logic [6:0]           key_tab [VOICES];
  logic [V_WIDTH-1:0]   age_tab [VOICES];

  // Scan position and candidate trackers
  logic [V_WIDTH-1:0]   scan_idx;
  logic                 match_found;
  logic [V_WIDTH-1:0]   match_idx;
  logic                 free_found;
  logic [V_WIDTH-1:0]   free_idx;
  logic                 rel_found;
  logic [V_WIDTH-1:0]   rel_idx;
  logic [V_WIDTH-1:0]   rel_age;
  logic                 old_found;
  logic [V_WIDTH-1:0]   old_idx;
  logic [V_WIDTH-1:0]   old_age;

`ifdef SUSTAIN_PEDAL_EN
  logic [VOICES-1:0]    hold;
  logic                 sus_q;
  logic                 sus_pend;
  logic                 sus_fall;
`endif

  // Decoded event kind and note-on target, from the captured event and scan results
  logic                 is_on_c;
  logic                 is_off_c;
  logic                 is_all_c;
  logic [V_WIDTH-1:0]   on_tgt_c;
  logic                 on_steal_c;

  // Event decode and target selection
  always_comb begin
    is_on_c    = 1'b0;
    is_off_c   = 1'b0;
    is_all_c   = 1'b0;
    on_tgt_c   = old_idx;
    on_steal_c = 1'b1;
    if (ev_type_q == EV_ON && ev_vel_q != 7'd0) begin
      is_on_c = 1'b1;
    end else if (ev_type_q == EV_OFF || ev_type_q == EV_ON) begin
      is_off_c = 1'b1;
    end else if (ev_type_q == EV_ALL) begin
      is_all_c = 1'b1;
    end
    if (match_found) begin
      on_tgt_c   = match_idx;
      on_steal_c = 1'b0;
    end else if (free_found) begin
      on_tgt_c   = free_idx;
      on_steal_c = 1'b0;
    end else if (rel_found) begin
      on_tgt_c   = rel_idx;
    end
  end

`ifdef SUSTAIN_PEDAL_EN
  // Sustain pedal falling edge
  always_comb begin
    sus_fall = sus_q && !sustain;
  end
`endif

  // Allocator FSM with registered outputs and tables
  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      state       <= ST_IDLE;
      ev_ready    <= 1'b1;
      ev_type_q   <= '0;
      ev_key_q    <= '0;
      ev_vel_q    <= '0;
      keys_on     <= '0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      cur_key_adr <= '0;
      cur_key_val <= '0;
      cur_vel_on  <= '0;
      cur_vel_off <= '0;
      stolen      <= 1'b0;
      off_miss    <= 1'b0;
      scan_idx    <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
      rel_found   <= 1'b0;
      rel_idx     <= '0;
      rel_age     <= '0;
      old_found   <= 1'b0;
      old_idx     <= '0;
      old_age     <= '0;
      for (int v = 0; v < int'(VOICES); v++) begin
        key_tab[v] <= '0;
        age_tab[v] <= V_WIDTH'(int'(VOICES) - 1 - v);
      end
`ifdef SUSTAIN_PEDAL_EN
      hold     <= '0;
      sus_q    <= 1'b0;
      sus_pend <= 1'b0;
`endif
    end else begin
      note_on  <= 1'b0;
      note_off <= 1'b0;
      stolen   <= 1'b0;
      off_miss <= 1'b0;
`ifdef SUSTAIN_PEDAL_EN
      sus_q <= sustain;
      if (state != ST_IDLE) begin
        sus_pend <= sus_pend | sus_fall;
      end
`endif
      case (state)
        ST_IDLE: begin
`ifdef SUSTAIN_PEDAL_EN
          // Release every held voice once the pedal has come up
          if (sus_pend) begin
            keys_on <= keys_on & ~hold;
            hold    <= '0;
          end
          sus_pend <= sus_fall;
`endif
          if (ev_valid) begin
            ev_type_q   <= ev_type;
            ev_key_q    <= ev_key;
            ev_vel_q    <= ev_vel;
            ev_ready    <= 1'b0;
            scan_idx    <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
            rel_found   <= 1'b0;
            old_found   <= 1'b0;
            state       <= (ev_type == EV_ALL) ? ST_COMMIT : ST_SCAN;
          end
        end

        ST_SCAN: begin
          if (!match_found && keys_on[scan_idx] && key_tab[scan_idx] == ev_key_q) begin
            match_found <= 1'b1;
            match_idx   <= scan_idx;
          end
          if (!free_found && voice_free[scan_idx] && !keys_on[scan_idx]) begin
            free_found <= 1'b1;
            free_idx   <= scan_idx;
          end
          if (!keys_on[scan_idx] && (!rel_found || age_tab[scan_idx] > rel_age)) begin
            rel_found <= 1'b1;
            rel_idx   <= scan_idx;
            rel_age   <= age_tab[scan_idx];
          end
          if (!old_found || age_tab[scan_idx] > old_age) begin
            old_found <= 1'b1;
            old_idx   <= scan_idx;
            old_age   <= age_tab[scan_idx];
          end
          if (scan_idx == V_WIDTH'(VOICES - 1)) begin
            scan_idx <= '0;
            state    <= ST_COMMIT;
          end else begin
            scan_idx <= scan_idx + V_WIDTH'(1);
          end
        end

        ST_COMMIT: begin
          if (is_on_c) begin
            keys_on[on_tgt_c] <= 1'b1;
            key_tab[on_tgt_c] <= ev_key_q;
            note_on           <= 1'b1;
            stolen            <= on_steal_c;
            cur_key_adr       <= on_tgt_c;
            cur_key_val       <= {1'b0, ev_key_q};
            cur_vel_on        <= {1'b0, ev_vel_q};
`ifdef SUSTAIN_PEDAL_EN
            hold[on_tgt_c]    <= 1'b0;
`endif
            // Target becomes youngest; voices younger than it age by one
            for (int v = 0; v < int'(VOICES); v++) begin
              if (V_WIDTH'(v) == on_tgt_c) begin
                age_tab[v] <= '0;
              end else if (age_tab[v] < age_tab[on_tgt_c]) begin
                age_tab[v] <= age_tab[v] + V_WIDTH'(1);
              end
            end
          end else if (is_off_c) begin
            if (match_found) begin
`ifdef SUSTAIN_PEDAL_EN
              if (sustain) begin
                hold[match_idx] <= 1'b1;
              end else begin
                keys_on[match_idx] <= 1'b0;
                note_off           <= 1'b1;
                cur_key_adr        <= match_idx;
                cur_key_val        <= {1'b0, ev_key_q};
                cur_vel_off        <= {1'b0, ev_vel_q};
              end
`else
              keys_on[match_idx] <= 1'b0;
              note_off           <= 1'b1;
              cur_key_adr        <= match_idx;
              cur_key_val        <= {1'b0, ev_key_q};
              cur_vel_off        <= {1'b0, ev_vel_q};
`endif
            end else begin
              off_miss <= 1'b1;
            end
          end else if (is_all_c) begin
            keys_on <= '0;
`ifdef SUSTAIN_PEDAL_EN
            hold    <= '0;
`endif
          end
          ev_ready <= 1'b1;
          state    <= ST_IDLE;
        end

        default: begin
          ev_ready <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// tb_voice_alloc: directed bench for voice_alloc with hand-computed expectations.
// Edge counts include the acceptance edge, so a scanned event commits on edge 10.
module tb_voice_alloc;

  localparam int unsigned VOICES  = 8;
  localparam int unsigned V_WIDTH = 3;

  localparam logic [1:0] EV_OFF = 2'b00;
  localparam logic [1:0] EV_ON  = 2'b01;
  localparam logic [1:0] EV_ALL = 2'b10;
  localparam logic [1:0] EV_RSV = 2'b11;

  logic               OSC_CLK;
  logic               iRST;
  logic               ev_valid;
  logic               ev_ready;
  logic [1:0]         ev_type;
  logic [6:0]         ev_key;
  logic [6:0]         ev_vel;
  logic [VOICES-1:0]  voice_free;
`ifdef SUSTAIN_PEDAL_EN
  logic               sustain;
`endif
  logic [VOICES-1:0]  keys_on;
  logic               note_on;
  logic               note_off;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [7:0]         cur_vel_off;
  logic               stolen;
  logic               off_miss;

  int checks;
  int errors;
  int lat;
  int seen;
  logic [VOICES-1:0] exp_keys;

  voice_alloc #(.VOICES(VOICES), .V_WIDTH(V_WIDTH)) dut (
    .OSC_CLK     (OSC_CLK),
    .iRST        (iRST),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_type     (ev_type),
    .ev_key      (ev_key),
    .ev_vel      (ev_vel),
    .voice_free  (voice_free),
`ifdef SUSTAIN_PEDAL_EN
    .sustain     (sustain),
`endif
    .keys_on     (keys_on),
    .note_on     (note_on),
    .note_off    (note_off),
    .cur_key_adr (cur_key_adr),
    .cur_key_val (cur_key_val),
    .cur_vel_on  (cur_vel_on),
    .cur_vel_off (cur_vel_off),
    .stolen      (stolen),
    .off_miss    (off_miss)
  );

  initial OSC_CLK = 1'b0;
  always #5 OSC_CLK = ~OSC_CLK;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Present one event, wait for ev_ready to return; returns edges since acceptance
  task automatic send(input logic [1:0] t, input logic [6:0] k, input logic [6:0] v,
                      output int edges);
    @(negedge OSC_CLK);
    ev_type  = t;
    ev_key   = k;
    ev_vel   = v;
    ev_valid = 1'b1;
    @(posedge OSC_CLK);
    #1;
    ev_valid = 1'b0;
    edges = 1;
    while (!ev_ready && edges < 40) begin
      @(posedge OSC_CLK);
      #1;
      edges++;
    end
    check("ready_back", 32'(ev_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge OSC_CLK);
    iRST = 1'b1;
    repeat (2) @(posedge OSC_CLK);
    @(negedge OSC_CLK);
    iRST = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    iRST       = 1'b1;
    ev_valid   = 1'b0;
    ev_type    = '0;
    ev_key     = '0;
    ev_vel     = '0;
    voice_free = 8'hFF;
`ifdef SUSTAIN_PEDAL_EN
    sustain    = 1'b0;
`endif
    repeat (3) @(posedge OSC_CLK);
    @(negedge OSC_CLK);
    iRST = 1'b0;

    // Reset state
    check("rst_ready",   32'(ev_ready),    32'd1);
    check("rst_keys",    32'(keys_on),     32'd0);
    check("rst_note_on", 32'(note_on),     32'd0);
    check("rst_adr",     32'(cur_key_adr), 32'd0);
    check("rst_val",     32'(cur_key_val), 32'd0);
    check("rst_miss",    32'(off_miss),    32'd0);

    // First note-on lands on voice 0 after 10 edges
    send(EV_ON, 7'd60, 7'd100, lat);
    check("t1_latency", 32'(lat),         32'd10);
    check("t1_note_on", 32'(note_on),     32'd1);
    check("t1_adr",     32'(cur_key_adr), 32'd0);
    check("t1_val",     32'(cur_key_val), 32'd60);
    check("t1_vel",     32'(cur_vel_on),  32'd100);
    check("t1_keys",    32'(keys_on),     32'h01);
    check("t1_stolen",  32'(stolen),      32'd0);
    @(posedge OSC_CLK);
    #1;
    check("t1_strobe_1cyc", 32'(note_on), 32'd0);

    // Fill voices 1..7 with only ungated voices reported free
    exp_keys = 8'h01;
    for (int i = 1; i < 8; i++) begin
      voice_free = ~exp_keys;
      send(EV_ON, 7'(60 + i), 7'd90, lat);
      check("t2_fill_adr",    32'(cur_key_adr), 32'(i));
      check("t2_fill_stolen", 32'(stolen),      32'd0);
      exp_keys[i] = 1'b1;
    end
    check("t2_full_keys", 32'(keys_on), 32'hFF);
    // All gated: oldest voice 0 is stolen
    voice_free = ~exp_keys;
    send(EV_ON, 7'd68, 7'd77, lat);
    check("t2_steal_adr",  32'(cur_key_adr), 32'd0);
    check("t2_steal_flag", 32'(stolen),      32'd1);
    check("t2_steal_val",  32'(cur_key_val), 32'd68);
    check("t2_steal_keys", 32'(keys_on),     32'hFF);

    // Retrigger: same key returns to its own voice without stealing
    do_reset();
    voice_free = 8'hFF;
    send(EV_ON, 7'd60, 7'd100, lat);
    send(EV_ON, 7'd60, 7'd80, lat);
    check("t3_adr",     32'(cur_key_adr), 32'd0);
    check("t3_stolen",  32'(stolen),      32'd0);
    check("t3_note_on", 32'(note_on),     32'd1);
    check("t3_vel",     32'(cur_vel_on),  32'd80);
    check("t3_keys",    32'(keys_on),     32'h01);

    // Note-off with no match: miss strobe, nothing else moves
    send(EV_OFF, 7'd61, 7'd40, lat);
    check("t4_miss",      32'(off_miss),    32'd1);
    check("t4_miss_off",  32'(note_off),    32'd0);
    check("t4_miss_keys", 32'(keys_on),     32'h01);
    check("t4_miss_adr",  32'(cur_key_adr), 32'd0);
    check("t4_miss_val",  32'(cur_key_val), 32'd60);
    // Note-on velocity 0 acts as note-off
    send(EV_ON, 7'd60, 7'd0, lat);
    check("t4_v0_off",    32'(note_off),    32'd1);
    check("t4_v0_on",     32'(note_on),     32'd0);
    check("t4_v0_keys",   32'(keys_on),     32'h00);
    check("t4_v0_vel",    32'(cur_vel_off), 32'd0);
    // Voices 0,1 still releasing: lowest idle voice is 2
    voice_free = 8'hFC;
    send(EV_ON, 7'd62, 7'd50, lat);
    check("t4_free_adr",  32'(cur_key_adr), 32'd2);
    check("t4_free_keys", 32'(keys_on),     32'h04);
    send(EV_OFF, 7'd62, 7'd33, lat);
    check("t4_off_adr",   32'(cur_key_adr), 32'd2);
    check("t4_off_vel",   32'(cur_vel_off), 32'd33);
    check("t4_off_keys",  32'(keys_on),     32'h00);
    // Ages now 0:1 1:7 2:0 3:6 4:5 5:4 6:3 7:2; nothing free -> oldest ungated (1)
    voice_free = 8'h00;
    send(EV_ON, 7'd70, 7'd10, lat);
    check("t4_rel_adr",    32'(cur_key_adr), 32'd1);
    check("t4_rel_stolen", 32'(stolen),      32'd1);
    check("t4_rel_keys",   32'(keys_on),     32'h02);
    // Ages 0:2 1:0 2:1 3:7 4:6 5:5 6:4 7:3 -> next ungated oldest is 3
    send(EV_ON, 7'd71, 7'd10, lat);
    check("t4_rel2_adr",  32'(cur_key_adr), 32'd3);
    check("t4_rel2_keys", 32'(keys_on),     32'h0A);
    // Retrigger key 70 on voice 1, then oldest ungated is voice 4
    send(EV_ON, 7'd70, 7'd20, lat);
    check("t4_retrig_adr",    32'(cur_key_adr), 32'd1);
    check("t4_retrig_stolen", 32'(stolen),      32'd0);
    send(EV_ON, 7'd72, 7'd10, lat);
    check("t4_rel3_adr",  32'(cur_key_adr), 32'd4);
    check("t4_rel3_keys", 32'(keys_on),     32'h1A);

    // Reset during scan aborts the event with no strobe
    @(negedge OSC_CLK);
    ev_type  = EV_ON;
    ev_key   = 7'd73;
    ev_vel   = 7'd10;
    ev_valid = 1'b1;
    @(posedge OSC_CLK);
    #1;
    ev_valid = 1'b0;
    repeat (3) @(posedge OSC_CLK);
    #1;
    iRST = 1'b1;
    #2;
    check("t5_rst_keys",    32'(keys_on), 32'h00);
    check("t5_rst_note_on", 32'(note_on), 32'd0);
    @(negedge OSC_CLK);
    iRST = 1'b0;
    @(posedge OSC_CLK);
    #1;
    check("t5_rst_ready", 32'(ev_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge OSC_CLK);
      #1;
      if (note_on || note_off) seen++;
    end
    check("t5_no_strobe", 32'(seen), 32'd0);

    // Reserved type is ignored; all-notes-off clears the gates after 2 edges
    voice_free = 8'hFF;
    send(EV_ON, 7'd60, 7'd64, lat);
    send(EV_ON, 7'd61, 7'd64, lat);
    send(EV_ON, 7'd62, 7'd64, lat);
    check("t5_three_keys", 32'(keys_on), 32'h07);
    send(EV_RSV, 7'd60, 7'd64, lat);
    check("t5_rsv_keys", 32'(keys_on),  32'h07);
    check("t5_rsv_on",   32'(note_on),  32'd0);
    check("t5_rsv_off",  32'(note_off), 32'd0);
    send(EV_ALL, 7'd0, 7'd0, lat);
    check("t5_all_latency", 32'(lat),      32'd2);
    check("t5_all_keys",    32'(keys_on),  32'h00);
    check("t5_all_on",      32'(note_on),  32'd0);
    check("t5_all_off",     32'(note_off), 32'd0);

`ifdef SUSTAIN_PEDAL_EN
    // Sustained note-off holds the gate until the pedal is released
    sustain = 1'b1;
    send(EV_ON, 7'd60, 7'd100, lat);
    check("t6_on_adr", 32'(cur_key_adr), 32'd0);
    send(EV_OFF, 7'd60, 7'd20, lat);
    check("t6_held_keys", 32'(keys_on),  32'h01);
    check("t6_held_off",  32'(note_off), 32'd0);
    @(negedge OSC_CLK);
    sustain = 1'b0;
    repeat (3) @(posedge OSC_CLK);
    #1;
    check("t6_release_keys", 32'(keys_on), 32'h00);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
